aes_inv_key_sched: RTL and testbench

Iterative AES-128 inverse key schedule. It runs the forward key expansion backwards.
- Input: the final round key (round NUM_ROUNDS).
- Output: every earlier round key, one per accepted beat, descending to round 0 (the cipher key).
- Place: the decryption datapath, which consumes round keys in reverse order without storing the whole expanded schedule.
- Reuses the codebase's rot_word and sbox (ports a/c) leaf modules: one rot_word and four sbox instances.

---
 rtl/aes_inv_key_sched.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_aes_inv_key_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_sched.sv
// ============================================================================
// aes_inv_key_sched -- iterative AES-128 inverse key schedule
//
// Purpose:
//   Takes the final round key (round NUM_ROUNDS) and walks the forward key
//   expansion backwards. It presents one earlier round key per accepted beat,
//   descending to round 0 (the cipher key). This lets the decryption datapath
//   consume round keys in reverse order without storing the whole expanded
//   schedule.
//
// Parameters:
//   NUM_ROUNDS  round index of the loaded key, legal range 1..10 (default 10)
//
// Ports:
//   pi_clk       in   1    clock, rising edge
//   pi_rst       in   1    asynchronous active-high reset
//   pi_start     in   1    load request, honoured only in IDLE
//   pi_last_key  in   128  round key NUM_ROUNDS, w0=[127:96] .. w3=[31:0]
//   pi_ready     in   1    downstream accepts po_rkey this cycle
//   po_rkey      out  128  current round key (same packing as pi_last_key)
//   po_round     out  4    round index of po_rkey
//   po_valid     out  1    po_rkey/po_round valid
//   po_busy      out  1    high whenever not IDLE
//   po_done      out  1    one-cycle pulse after round 0 is accepted
//
// Optional feature (macro AES_INV_KEY_SCHED_CHECK_EN):
//   pi_ref_key   in   128  reference cipher key, captured on the accepted start
//   po_match     out  1    on the po_done cycle: round-0 key == reference
//
// Also contains the rot_word and sbox leaf modules (ports a -> c).
// ============================================================================

// ----------------------------------------------------------------------------
// rot_word: cyclic left rotation of a 32-bit word by one byte.
// ----------------------------------------------------------------------------
module rot_word (
    input  logic [31:0] a,
    output logic [31:0] c
);
    assign c = {a[23:0], a[31:24]};
endmodule

// ----------------------------------------------------------------------------
// sbox: AES forward S-box.
// The table is computed rather than stored. The multiplicative inverse in
// GF(2^8) is x^254, and it is followed by the standard affine transform.
// ----------------------------------------------------------------------------
module sbox (
    input  logic [7:0] a,
    output logic [7:0] c
);
    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] prod;
        logic [7:0] acc;
        prod = 8'h00;
        acc  = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) begin
                prod = prod ^ acc;
            end else begin
                prod = prod;
            end
            acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
        end
        return prod;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = x;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_fn(input logic [7:0] x);
        logic [7:0] inv;
        inv = gf_inv(x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                   ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    // Combinational S-box lookup
    always_comb begin
        c = sbox_fn(a);
    end
endmodule

// ----------------------------------------------------------------------------
// aes_inv_key_sched: top level
// ----------------------------------------------------------------------------
module aes_inv_key_sched #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         pi_clk,
    input  logic         pi_rst,
    input  logic         pi_start,
    input  logic [127:0] pi_last_key,
`ifdef AES_INV_KEY_SCHED_CHECK_EN
    input  logic [127:0] pi_ref_key,
    output logic         po_match,
`endif
    input  logic         pi_ready,
    output logic [127:0] po_rkey,
    output logic [3:0]   po_round,
    output logic         po_valid,
    output logic         po_busy,
    output logic         po_done
);

    localparam logic [3:0] LP_LOAD_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Round constant byte rc_r. Rounds outside 1..10 (round 0 in
    // particular) yield 0, so an idle rcon register reads 0.
    function automatic logic [7:0] rcon_lut(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t         r_state;
    logic [127:0]   r_rkey;
    logic [3:0]     r_round;
    logic           r_valid;
    logic           r_busy;
    logic           r_done;
    // Holds rc for the round currently shown on po_round
    logic [7:0]     r_rcon;

    state_t         w_state_nxt;
    logic [127:0]   w_rkey_nxt;
    logic [3:0]     w_round_nxt;
    logic           w_valid_nxt;
    logic           w_busy_nxt;
    logic           w_done_nxt;
    logic [7:0]     w_rcon_nxt;

`ifdef AES_INV_KEY_SCHED_CHECK_EN
    logic [127:0]   r_ref_key;
    logic           r_match;
    logic [127:0]   w_ref_key_nxt;
    logic           w_match_nxt;
`endif

    // ------------------------------------------------------------------
    // Backward step datapath: built purely from registered state
    // ------------------------------------------------------------------
    logic [31:0]    w_k0, w_k1, w_k2, w_k3;
    logic [31:0]    w_p0, w_p1, w_p2, w_p3;
    logic [31:0]    w_rot;
    logic [31:0]    w_sub;
    logic [127:0]   w_prev_key;

    assign w_k0 = r_rkey[127:96];
    assign w_k1 = r_rkey[95:64];
    assign w_k2 = r_rkey[63:32];
    assign w_k3 = r_rkey[31:0];

    // Undo the forward XOR chain: w[i] = w[i-1] ^ w[i-4]
    assign w_p3 = w_k3 ^ w_k2;
    assign w_p2 = w_k2 ^ w_k1;
    assign w_p1 = w_k1 ^ w_k0;

    rot_word u_rot_word (
        .a (w_p3),
        .c (w_rot)
    );

    sbox u_sbox_0 (.a(w_rot[31:24]), .c(w_sub[31:24]));
    sbox u_sbox_1 (.a(w_rot[23:16]), .c(w_sub[23:16]));
    sbox u_sbox_2 (.a(w_rot[15:8]),  .c(w_sub[15:8]));
    sbox u_sbox_3 (.a(w_rot[7:0]),   .c(w_sub[7:0]));

    assign w_p0       = w_k0 ^ w_sub ^ {r_rcon, 24'h000000};
    assign w_prev_key = {w_p0, w_p1, w_p2, w_p3};

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; every register holds by default
    always_comb begin
        w_state_nxt = r_state;
        w_rkey_nxt  = r_rkey;
        w_round_nxt = r_round;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_rcon_nxt  = r_rcon;
`ifdef AES_INV_KEY_SCHED_CHECK_EN
        w_ref_key_nxt = r_ref_key;
        w_match_nxt   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_valid_nxt = 1'b0;
                if (pi_start) begin
                    w_state_nxt = ST_RUN;
                    w_rkey_nxt  = pi_last_key;
                    w_round_nxt = LP_LOAD_ROUND;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_rcon_nxt  = rcon_lut(LP_LOAD_ROUND);
`ifdef AES_INV_KEY_SCHED_CHECK_EN
                    w_ref_key_nxt = pi_ref_key;
`endif
                end else begin
                    w_busy_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                // pi_start is deliberately not looked at in this state
                if (r_valid && pi_ready) begin
                    if (r_round != 4'd0) begin
                        w_rkey_nxt  = w_prev_key;
                        w_round_nxt = r_round - 4'd1;
                        w_rcon_nxt  = rcon_lut(r_round - 4'd1);
                    end else begin
                        // Round 0 accepted: keep the cipher key on po_rkey
                        w_state_nxt = ST_IDLE;
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
`ifdef AES_INV_KEY_SCHED_CHECK_EN
                        w_match_nxt = (r_rkey == r_ref_key);
`endif
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            r_rkey  <= 128'h0;
            r_round <= 4'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rcon  <= 8'h00;
        end else begin
            r_rkey  <= w_rkey_nxt;
            r_round <= w_round_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_rcon  <= w_rcon_nxt;
        end
    end

`ifdef AES_INV_KEY_SCHED_CHECK_EN
    // Reference key capture and end-of-run comparison result
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            r_ref_key <= 128'h0;
            r_match   <= 1'b0;
        end else begin
            r_ref_key <= w_ref_key_nxt;
            r_match   <= w_match_nxt;
        end
    end

    assign po_match = r_match;
`endif

    assign po_rkey  = r_rkey;
    assign po_round = r_round;
    assign po_valid = r_valid;
    assign po_busy  = r_busy;
    assign po_done  = r_done;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// ============================================================================
// tb_aes_inv_key_sched -- directed, table-driven bench for aes_inv_key_sched.
// The main instance uses NUM_ROUNDS=10. A second instance uses NUM_ROUNDS=1.
// The FIPS-197 expansion of key 2b7e151628aed2a6abf7158809cf4f3c supplies
// the expected round keys.
// ============================================================================
`timescale 1ns/1ps

module tb_aes_inv_key_sched;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
    } beat_t;

    logic         pi_clk;
    logic         pi_rst;
    logic         pi_start;
    logic [127:0] pi_last_key;
    logic         pi_ready;
    logic [127:0] po_rkey;
    logic [3:0]   po_round;
    logic         po_valid;
    logic         po_busy;
    logic         po_done;

    logic         s1_start;
    logic [127:0] s1_last_key;
    logic         s1_ready;
    logic [127:0] o1_rkey;
    logic [3:0]   o1_round;
    logic         o1_valid;
    logic         o1_busy;
    logic         o1_done;

`ifdef AES_INV_KEY_SCHED_CHECK_EN
    logic [127:0] pi_ref_key;
    logic         po_match;
    logic [127:0] s1_ref_key;
    logic         o1_match;
    logic         exp_match;
`endif

    int n_checks;
    int n_errors;

    beat_t tbl[11];

    localparam logic [127:0] KEY10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_inv_key_sched #(.NUM_ROUNDS(10)) u_dut (
        .pi_clk      (pi_clk),
        .pi_rst      (pi_rst),
        .pi_start    (pi_start),
        .pi_last_key (pi_last_key),
`ifdef AES_INV_KEY_SCHED_CHECK_EN
        .pi_ref_key  (pi_ref_key),
        .po_match    (po_match),
`endif
        .pi_ready    (pi_ready),
        .po_rkey     (po_rkey),
        .po_round    (po_round),
        .po_valid    (po_valid),
        .po_busy     (po_busy),
        .po_done     (po_done)
    );

    aes_inv_key_sched #(.NUM_ROUNDS(1)) u_dut1 (
        .pi_clk      (pi_clk),
        .pi_rst      (pi_rst),
        .pi_start    (s1_start),
        .pi_last_key (s1_last_key),
`ifdef AES_INV_KEY_SCHED_CHECK_EN
        .pi_ref_key  (s1_ref_key),
        .po_match    (o1_match),
`endif
        .pi_ready    (s1_ready),
        .po_rkey     (o1_rkey),
        .po_round    (o1_round),
        .po_valid    (o1_valid),
        .po_busy     (o1_busy),
        .po_done     (o1_done)
    );

    initial pi_clk = 1'b0;
    always #5 pi_clk = ~pi_clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one full schedule on the NUM_ROUNDS=10 instance.
    // mode 0: ready always 1; mode 1: random ready; mode 2: restart attempt at round 6
    task automatic run_keys(input int mode);
        int            idx;
        int            cycles;
        logic          rdy;
        logic          held;
        logic [127:0]  prev_key;
        logic [3:0]    prev_round;
        idx    = 0;
        cycles = 0;
        held   = 1'b0;
        prev_key   = 128'h0;
        prev_round = 4'd0;
        @(negedge pi_clk);
        pi_last_key = KEY10;
        pi_start    = 1'b1;
        @(negedge pi_clk);
        pi_start = 1'b0;
        chk("first_busy", {127'h0, po_busy}, 128'h1);
        while (idx < 11 && cycles < 400) begin
            if (!po_valid) begin
                chk("valid_drop", {127'h0, po_valid}, 128'h1);
                break;
            end
            if (held) begin
                chk("hold_key", po_rkey, prev_key);
                chk("hold_round", {124'h0, po_round}, {124'h0, prev_round});
            end
            chk("beat_round", {124'h0, po_round}, {124'h0, tbl[idx].round});
            chk("beat_key", po_rkey, tbl[idx].key);
            rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            pi_ready = rdy;
            if (mode == 2 && po_round == 4'd6) begin
                pi_start    = 1'b1;
                pi_last_key = 128'h0123456789abcdef0123456789abcdef;
            end else begin
                pi_start = 1'b0;
            end
            held       = !rdy;
            prev_key   = po_rkey;
            prev_round = po_round;
            if (rdy) idx++;
            @(negedge pi_clk);
            cycles++;
        end
        pi_start = 1'b0;
        chk("beat_count", 128'(idx), 128'd11);
        chk("done_pulse", {127'h0, po_done}, 128'h1);
        chk("done_valid", {127'h0, po_valid}, 128'h0);
        chk("done_busy", {127'h0, po_busy}, 128'h0);
        chk("done_key", po_rkey, KEY0);
`ifdef AES_INV_KEY_SCHED_CHECK_EN
        chk("match", {127'h0, po_match}, {127'h0, exp_match});
`endif
        pi_ready = 1'b1;
        @(negedge pi_clk);
        chk("done_one_cycle", {127'h0, po_done}, 128'h0);
        chk("idle_key_kept", po_rkey, KEY0);
    endtask

    initial begin
        int cnt;
        n_checks = 0;
        n_errors = 0;
        tbl[0]  = '{4'd10, KEY10};
        tbl[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        tbl[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        tbl[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        tbl[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        tbl[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        tbl[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        tbl[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        tbl[9]  = '{4'd1,  KEY1};
        tbl[10] = '{4'd0,  KEY0};

        pi_rst      = 1'b1;
        pi_start    = 1'b0;
        pi_last_key = 128'h0;
        pi_ready    = 1'b1;
        s1_start    = 1'b0;
        s1_last_key = 128'h0;
        s1_ready    = 1'b1;
`ifdef AES_INV_KEY_SCHED_CHECK_EN
        pi_ref_key  = KEY0;
        s1_ref_key  = KEY0;
        exp_match   = 1'b1;
`endif
        #12;
        chk("rst_key", po_rkey, 128'h0);
        chk("rst_round", {124'h0, po_round}, 128'h0);
        chk("rst_valid", {127'h0, po_valid}, 128'h0);
        chk("rst_busy", {127'h0, po_busy}, 128'h0);
        chk("rst_done", {127'h0, po_done}, 128'h0);
        @(negedge pi_clk);
        pi_rst = 1'b0;
        @(negedge pi_clk);
        chk("idle_valid", {127'h0, po_valid}, 128'h0);

        // FIPS-197 vector, continuous ready
        run_keys(0);
        // Random backpressure
        run_keys(1);
        run_keys(1);
        // Start pulse while busy is ignored
        run_keys(2);

        // Async reset at round 5, between clock edges
        @(negedge pi_clk);
        pi_last_key = KEY10;
        pi_start    = 1'b1;
        pi_ready    = 1'b1;
        @(negedge pi_clk);
        pi_start = 1'b0;
        cnt = 0;
        while (po_round != 4'd5 && cnt < 30) begin
            @(negedge pi_clk);
            cnt++;
        end
        chk("reach_round5", {124'h0, po_round}, 128'd5);
        #2 pi_rst = 1'b1;
        #1;
        chk("arst_valid", {127'h0, po_valid}, 128'h0);
        chk("arst_busy", {127'h0, po_busy}, 128'h0);
        chk("arst_key", po_rkey, 128'h0);
        chk("arst_round", {124'h0, po_round}, 128'h0);
        chk("arst_done", {127'h0, po_done}, 128'h0);
        @(negedge pi_clk);
        pi_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pi_clk);
            chk("arst_no_done", {127'h0, po_done}, 128'h0);
            chk("arst_idle", {127'h0, po_valid}, 128'h0);
        end
        run_keys(0);

        // NUM_ROUNDS=1 instance: two beats then done
        @(negedge pi_clk);
        s1_last_key = KEY1;
        s1_start    = 1'b1;
        @(negedge pi_clk);
        s1_start = 1'b0;
        chk("n1_valid1", {127'h0, o1_valid}, 128'h1);
        chk("n1_round1", {124'h0, o1_round}, 128'd1);
        chk("n1_key1", o1_rkey, KEY1);
        @(negedge pi_clk);
        chk("n1_valid0", {127'h0, o1_valid}, 128'h1);
        chk("n1_round0", {124'h0, o1_round}, 128'd0);
        chk("n1_key0", o1_rkey, KEY0);
        @(negedge pi_clk);
        chk("n1_done", {127'h0, o1_done}, 128'h1);
        chk("n1_end_valid", {127'h0, o1_valid}, 128'h0);
        chk("n1_end_busy", {127'h0, o1_busy}, 128'h0);
        @(negedge pi_clk);
        chk("n1_done_once", {127'h0, o1_done}, 128'h0);

`ifdef AES_INV_KEY_SCHED_CHECK_EN
        // Reference compare: one flipped bit must clear po_match
        pi_ref_key = KEY0 ^ 128'h0000_0000_0000_0100_0000_0000_0000_0000;
        exp_match  = 1'b0;
        run_keys(0);
        pi_ref_key = KEY0;
        exp_match  = 1'b1;
        run_keys(0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
